full_adder: RTL and testbench



---
 rtl/full_adder_pkg.sv | 15 +
 rtl/full_adder_cell.sv | 18 +
 rtl/full_adder.sv | 54 +++++
 tb/tb_full_adder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared helpers for the full adder slice: the carry (majority) function used
// by each 1-bit cell, and the shape of one registered adder result.
package full_adder_pkg;

    // Carry out of a 1-bit full adder: set when at least two inputs are set.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Parity of three bits: the sum bit of a 1-bit full adder.
    function automatic logic xor3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One bit of the ripple-carry adder: purely combinational, no state.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    // Sum and carry of one bit position; X on any input is allowed to propagate.
    always_comb begin
        s  = xor3(a, b, cin);
        co = maj3(a, b, cin);
    end

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with two views of the result: a zero-latency
// combinational {cout, sum} and a registered copy qualified by out_valid.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            full_adder_cell u_cell (
                .a   (a[i]),
                .b   (b[i]),
                .cin (carry[i]),
                .s   (sum[i]),
                .co  (carry[i+1])
            );
        end
    endgenerate

    // Capture the combinational result when qualified; the data holds when
    // idle so the last result stays observable, while out_valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= sum;
                cout_q <= cout;
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a1, b1, cin1, iv1;
    logic       sum1, cout1, sum_q1, cout_q1, ov1;

    logic [3:0] a4, b4;
    logic       cin4, iv4;
    logic [3:0] sum4, sum_q4;
    logic       cout4, cout_q4, ov4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_fa1 (
        .clk(clk), .rst_n(rst_n),
        .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .sum(sum1), .cout(cout1),
        .sum_q(sum_q1), .cout_q(cout_q1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(4)) u_fa4 (
        .clk(clk), .rst_n(rst_n),
        .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
        .sum(sum4), .cout(cout4),
        .sum_q(sum_q4), .cout_q(cout_q4), .out_valid(ov4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference for the width-4 registered view: plain integer sum, held per cycle.
    int ref_total;
    int exp_sq, exp_cq, exp_ov;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
        a4 = 0; b4 = 0; cin4 = 0; iv4 = 0;

        #12;
        check("rst_sum_q1",  sum_q1,  0);
        check("rst_cout_q1", cout_q1, 0);
        check("rst_ov1",     ov1,     0);
        check("rst_sum_q4",  sum_q4,  0);
        check("rst_ov4",     ov4,     0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 1-bit truth table, 10 ns per vector.
        for (int v = 0; v < 8; v++) begin
            a1   = v[2];
            b1   = v[1];
            cin1 = v[0];
            #1;
            ref_total = v[2] + v[1] + v[0];
            check($sformatf("tt_sum_%0d", v),  sum1,  ref_total % 2);
            check($sformatf("tt_cout_%0d", v), cout1, ref_total / 2);
            #9;
        end

        // Registered capture, then hold with out_valid dropping.
        @(negedge clk);
        a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
        @(posedge clk); #1;
        check("reg_sum_q",  sum_q1,  1);
        check("reg_cout_q", cout_q1, 1);
        check("reg_ov",     ov1,     1);
        @(negedge clk);
        iv1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        @(posedge clk); #1;
        check("hold_ov",     ov1,     0);
        check("hold_sum_q",  sum_q1,  1);
        check("hold_cout_q", cout_q1, 1);

        // Asynchronous reset mid-cycle while a result is valid.
        @(negedge clk);
        a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
        @(posedge clk); #1;
        check("pre_rst_ov", ov1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum_q",  sum_q1,  0);
        check("arst_cout_q", cout_q1, 0);
        check("arst_ov",     ov1,     0);
        check("arst_sum",    sum1,    1);
        check("arst_cout",   cout1,   1);
        @(negedge clk);
        iv1 = 0;
        rst_n = 1'b1;

        // Width-4 carry ripple boundaries.
        a4 = 4'hF; b4 = 4'h0; cin4 = 1;
        #1;
        check("rip_f0_sum",  sum4,  4'h0);
        check("rip_f0_cout", cout4, 1);
        a4 = 4'hF; b4 = 4'hF; cin4 = 1;
        #1;
        check("rip_ff_sum",  sum4,  4'hF);
        check("rip_ff_cout", cout4, 1);

        // Width-4 random vectors with random in_valid.
        exp_sq = 0; exp_cq = 0; exp_ov = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            a4   = 4'($urandom_range(0, 15));
            b4   = 4'($urandom_range(0, 15));
            cin4 = 1'($urandom_range(0, 1));
            iv4  = 1'($urandom_range(0, 1));
            #1;
            ref_total = int'(a4) + int'(b4) + int'(cin4);
            check("rnd_sum",  sum4,  ref_total % 16);
            check("rnd_cout", cout4, ref_total / 16);
            @(posedge clk); #1;
            if (iv4) begin
                exp_sq = ref_total % 16;
                exp_cq = ref_total / 16;
            end
            exp_ov = iv4;
            check("rnd_ov", ov4, exp_ov);
            if (exp_ov != 0) begin
                check("rnd_sum_q",  sum_q4,  exp_sq);
                check("rnd_cout_q", cout_q4, exp_cq);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
